isr_service_tracker: RTL and testbench

Parametrised successor to the current-ISR decoder. It accepts normal and fast interrupt requests from N_IO IO modules, arbitrates them, and presents one pending vector to the CPU. It tracks which ISR is currently being serviced, with one level of nesting (fast preempts normal), and drives a one-hot acknowledge to the IO module being serviced. It sits between the IO modules' request lines and the CPU's interrupt/return handshake.

---
 rtl/isr_service_tracker.sv | 137 +++++++++++++
 tb/tb_isr_service_tracker.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/isr_service_tracker.sv
// rtl/isr_service_tracker.sv - interrupt arbiter and current-ISR tracker with one level of fast-over-normal nesting
module isr_service_tracker #(
   parameter int N_IO = 3,
   parameter int ID_W = 3
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [N_IO-1:0] irq_req,
   input  logic [N_IO-1:0] firq_req,
   input  logic            irq_en,
   input  logic            cpu_ack,
   input  logic            reti,
   output logic            int_pending,
   output logic [ID_W-1:0] vec_id,
   output logic [ID_W-1:0] cur_id,
   output logic [N_IO-1:0] io_ack,
   output logic            nested
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] PEND      = 3'd1;
   localparam logic [2:0] SERVICE   = 3'd2;
   localparam logic [2:0] NEST_PEND = 3'd3;
   localparam logic [2:0] NESTED    = 3'd4;

   localparam logic [ID_W-1:0] MAX_NORMAL_ID = ID_W'(N_IO);

   logic [2:0]      state_q, state_d;
   logic [ID_W-1:0] vec_q, vec_d;
   logic [ID_W-1:0] cur_q, cur_d;
   logic [ID_W-1:0] saved_q, saved_d;

   logic            fast_any, norm_any;
   logic [ID_W-1:0] fast_id, norm_id;

   // Ascending scan so the highest IO index (lowest k) is the last write and wins.
   always_comb begin
      fast_any = 1'b0;
      norm_any = 1'b0;
      fast_id  = '0;
      norm_id  = '0;
      for (int i = 0; i < N_IO; i++) begin
         if (firq_req[i]) begin
            fast_any = 1'b1;
            fast_id  = ID_W'(2 * N_IO - i);
         end
         if (irq_req[i] && irq_en) begin
            norm_any = 1'b1;
            norm_id  = ID_W'(N_IO - i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cur_d   = cur_q;
      saved_d = saved_q;
      case (state_q)
         IDLE: begin
            if (fast_any || norm_any) begin
               vec_d   = fast_any ? fast_id : norm_id;
               state_d = PEND;
            end
         end
         PEND: begin
            if (cpu_ack) begin
               cur_d   = vec_q;
               vec_d   = '0;
               state_d = SERVICE;
            end
         end
         SERVICE: begin
            if (reti) begin
               cur_d   = '0;
               state_d = IDLE;
            end else if (cur_q <= MAX_NORMAL_ID && fast_any) begin
               vec_d   = fast_id;
               state_d = NEST_PEND;
            end
         end
         NEST_PEND: begin
            // reti has priority: the normal ISR ends and the fast vector stays presented.
            if (reti) begin
               cur_d   = '0;
               state_d = PEND;
            end else if (cpu_ack) begin
               saved_d = cur_q;
               cur_d   = vec_q;
               vec_d   = '0;
               state_d = NESTED;
            end
         end
         NESTED: begin
            if (reti) begin
               cur_d   = saved_q;
               saved_d = '0;
               state_d = SERVICE;
            end
         end
         default: begin
            state_d = IDLE;
            vec_d   = '0;
            cur_d   = '0;
            saved_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         vec_q   <= '0;
         cur_q   <= '0;
         saved_q <= '0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cur_q   <= cur_d;
         saved_q <= saved_d;
      end
   end

   always_comb begin
      io_ack = '0;
      for (int i = 0; i < N_IO; i++) begin
         io_ack[i] = (cur_q != '0) &&
                     (cur_q == ID_W'(N_IO - i) || cur_q == ID_W'(2 * N_IO - i));
      end
   end

   assign int_pending = (state_q == PEND) || (state_q == NEST_PEND);
   assign vec_id      = int_pending ? vec_q : '0;
   assign cur_id      = cur_q;
   assign nested      = (state_q == NESTED);

endmodule

// File: tb/tb_isr_service_tracker.sv
// tb/tb_isr_service_tracker.sv - directed scoreboard bench for isr_service_tracker
module tb_isr_service_tracker;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [2:0] irq_req, firq_req;
   logic       irq_en, cpu_ack, reti;
   logic       int_pending, nested;
   logic [2:0] vec_id, cur_id, io_ack;

   isr_service_tracker #(.N_IO(3), .ID_W(3)) dut (
      .clk(clk), .reset_n(reset_n), .irq_req(irq_req), .firq_req(firq_req),
      .irq_en(irq_en), .cpu_ack(cpu_ack), .reti(reti), .int_pending(int_pending),
      .vec_id(vec_id), .cur_id(cur_id), .io_ack(io_ack), .nested(nested)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [10:0] v;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;

   function automatic logic [10:0] ex(input logic p, input logic [2:0] v, input logic [2:0] c,
                                      input logic [2:0] a, input logic n);
      return {p, v, c, a, n};
   endfunction

   task automatic push(input string tag, input logic [10:0] v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      sb.push_back(e);
   endtask

   task automatic compare_next();
      exp_t        e;
      logic [10:0] obs;
      e   = sb.pop_front();
      obs = {int_pending, vec_id, cur_id, io_ack, nested};
      vectors++;
      assert (obs === e.v) else begin
         miscompares++;
         $error("FAIL %s observed={pend,vec,cur,ack,nest}=%b expected=%b", e.tag, obs, e.v);
      end
   endtask

   // One clock step: expectation queued with the stimulus, checked #1 after the edge.
   task automatic cyc(input string tag, input logic [10:0] v);
      push(tag, v);
      @(posedge clk);
      #1;
      compare_next();
      cpu_ack = 1'b0;
      reti    = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; irq_req = '0; firq_req = '0; irq_en = 1'b0; cpu_ack = 1'b0; reti = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      push("reset", ex(0, 0, 0, 3'b000, 0));
      compare_next();
      reset_n = 1'b1;

      // Basic normal request, ack, return.
      irq_en = 1'b1; irq_req = 3'b001;
      cyc("t1_req", ex(1, 3, 0, 3'b000, 0));
      irq_req = '0; cpu_ack = 1'b1;
      cyc("t1_ack", ex(0, 0, 3, 3'b001, 0));
      reti = 1'b1;
      cyc("t1_reti", ex(0, 0, 0, 3'b000, 0));
      cpu_ack = 1'b1;
      cyc("idle_ack_ignored", ex(0, 0, 0, 3'b000, 0));
      reti = 1'b1;
      cyc("idle_reti_ignored", ex(0, 0, 0, 3'b000, 0));

      // Fast beats normal.
      irq_req = 3'b101; firq_req = 3'b010;
      cyc("t2_req", ex(1, 5, 0, 3'b000, 0));
      irq_req = '0; firq_req = '0; cpu_ack = 1'b1;
      cyc("t2_ack", ex(0, 0, 5, 3'b010, 0));
      reti = 1'b1;
      cyc("t2_reti", ex(0, 0, 0, 3'b000, 0));

      // Nesting of fast over normal.
      irq_req = 3'b100;
      cyc("t3_req", ex(1, 1, 0, 3'b000, 0));
      irq_req = '0; cpu_ack = 1'b1;
      cyc("t3_ack", ex(0, 0, 1, 3'b100, 0));
      firq_req = 3'b001;
      cyc("t3_nest_pend", ex(1, 6, 1, 3'b100, 0));
      firq_req = '0; cpu_ack = 1'b1;
      cyc("t3_nest_ack", ex(0, 0, 6, 3'b001, 1));
      cpu_ack = 1'b1;
      cyc("t3_nested_ack_ignored", ex(0, 0, 6, 3'b001, 1));
      reti = 1'b1;
      cyc("t3_restore", ex(0, 0, 1, 3'b100, 0));
      reti = 1'b1;
      cyc("t3_reti_idle", ex(0, 0, 0, 3'b000, 0));

      // Fast ISR is not preempted; return bubble before next arbitration.
      firq_req = 3'b100;
      cyc("t4_req", ex(1, 4, 0, 3'b000, 0));
      cpu_ack = 1'b1; firq_req = 3'b010; irq_req = 3'b001;
      cyc("t4_ack", ex(0, 0, 4, 3'b100, 0));
      cyc("t4_no_preempt", ex(0, 0, 4, 3'b100, 0));
      reti = 1'b1;
      cyc("t4_bubble", ex(0, 0, 0, 3'b000, 0));
      cyc("t4_rearb", ex(1, 5, 0, 3'b000, 0));
      firq_req = 3'b100;
      cyc("t4_pend_frozen", ex(1, 5, 0, 3'b000, 0));
      reti = 1'b1;
      cyc("t4_pend_reti_ignored", ex(1, 5, 0, 3'b000, 0));
      firq_req = '0; irq_req = '0; cpu_ack = 1'b1;
      cyc("t4_ack2", ex(0, 0, 5, 3'b010, 0));
      reti = 1'b1;
      cyc("t4_reti2", ex(0, 0, 0, 3'b000, 0));

      // NEST_PEND with simultaneous cpu_ack and reti: reti wins.
      irq_req = 3'b010;
      cyc("t5_req", ex(1, 2, 0, 3'b000, 0));
      irq_req = '0; cpu_ack = 1'b1;
      cyc("t5_ack", ex(0, 0, 2, 3'b010, 0));
      firq_req = 3'b100;
      cyc("t5_nest_pend", ex(1, 4, 2, 3'b010, 0));
      firq_req = '0;
      cyc("t5_vec_held", ex(1, 4, 2, 3'b010, 0));
      cpu_ack = 1'b1; reti = 1'b1;
      cyc("t5_ack_reti", ex(1, 4, 0, 3'b000, 0));
      cpu_ack = 1'b1;
      cyc("t5_ack_fast", ex(0, 0, 4, 3'b100, 0));
      reti = 1'b1;
      cyc("t5_reti", ex(0, 0, 0, 3'b000, 0));

      // Masking, then asynchronous reset mid-nest.
      irq_en = 1'b0; irq_req = 3'b111;
      cyc("t6_masked", ex(0, 0, 0, 3'b000, 0));
      cyc("t6_masked2", ex(0, 0, 0, 3'b000, 0));
      irq_en = 1'b1;
      cyc("t6_unmask", ex(1, 1, 0, 3'b000, 0));
      irq_req = '0; cpu_ack = 1'b1;
      cyc("t6_ack", ex(0, 0, 1, 3'b100, 0));
      firq_req = 3'b010;
      cyc("t6_nest_pend", ex(1, 5, 1, 3'b100, 0));
      firq_req = '0; cpu_ack = 1'b1;
      cyc("t6_nested", ex(0, 0, 5, 3'b010, 1));
      #2;
      reset_n = 1'b0;
      #1;
      push("t6_async_reset", ex(0, 0, 0, 3'b000, 0));
      compare_next();
      reset_n = 1'b1;
      reti = 1'b1;
      cyc("t6_no_restore", ex(0, 0, 0, 3'b000, 0));
      cyc("t6_idle", ex(0, 0, 0, 3'b000, 0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
